// File: rtl/alu_seq16.sv
// alu_seq16: 16-bit ADD HL,rr / INC rr / DEC rr / ADD SP,e8 sequencer.
// The 16-bit operation is split over two M-cycles on a shared 8-bit ALU:
// the low byte first, then the high byte with the ALU's own held carry.
// Flags are rebuilt from the operand and result bytes seen on the ALU bus.

package gate_boy_pkg;
    localparam int DATA_WIDTH   = 8;
    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_ADC = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_SUB = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_SBC = 4'd3;
endpackage

module alu_seq16
    import gate_boy_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    phi,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [15:0]             req_a,
    input  logic [15:0]             req_b,
    input  logic [3:0]              req_flags,
    output logic [DATA_WIDTH-1:0]   alu_operand_A,
    output logic [DATA_WIDTH-1:0]   alu_operand_B,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_result,
    output logic [3:0]              rsp_flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD16     = 2'd0,
        OP_INC16     = 2'd1,
        OP_DEC16     = 2'd2,
        OP_ADD_SP_E8 = 2'd3
    } op_t;

    state_t      state;
    state_t      state_next;

    op_t         op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  flags_q;
    logic [7:0]  res_lo_q;
    logic        h_lo_q;
    logic        c_lo_q;

    logic        accept;
    logic        lo_step;
    logic        hi_step;
    logic        byte_h;
    logic        byte_c_add;
    logic        byte_b_sub;
    logic [3:0]  flags_next;

    // Carry out of bit 7 for an add: majority of a7, b7 and the carry into bit 7.
    function automatic logic add_carry(input logic a7, input logic b7, input logic r7);
        logic c7;
        c7 = a7 ^ b7 ^ r7;
        return (a7 & b7) | ((a7 | b7) & c7);
    endfunction

    // Borrow out of bit 7 for a subtract, recovered from a7, b7 and r7.
    function automatic logic sub_borrow(input logic a7, input logic b7, input logic r7);
        return (~a7 & b7) | (~(a7 ^ b7) & r7);
    endfunction

    assign accept  = (state == S_IDLE) & phi & req_valid;
    assign lo_step = (state == S_LO) & phi;
    assign hi_step = (state == S_HI) & phi;

    // Carry/borrow into bit 4 is the same XOR for add and subtract.
    assign byte_h     = alu_operand_A[4] ^ alu_operand_B[4] ^ alu_result[4];
    assign byte_c_add = add_carry(alu_operand_A[7], alu_operand_B[7], alu_result[7]);
    assign byte_b_sub = sub_borrow(alu_operand_A[7], alu_operand_B[7], alu_result[7]);

    // State register; reset always wins over phi and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: byte steps advance on phi, the response leaves on any handshake edge.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (phi && req_valid) state_next = S_LO;
            S_LO:   if (phi)              state_next = S_HI;
            S_HI:   if (phi)              state_next = S_DONE;
            S_DONE: if (rsp_ready)        state_next = S_IDLE;
            default:                      state_next = S_IDLE;
        endcase
    end

    // Outputs: ALU bus per byte step, idle ADD 0+0 otherwise, and the handshake flags.
    always_comb begin
        alu_operand_A = '0;
        alu_operand_B = '0;
        alu_opcode    = ALU_OP_ADD;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_LO: begin
                alu_operand_A = a_q[7:0];
                case (op_q)
                    OP_ADD16: begin
                        alu_operand_B = b_q[7:0];
                        alu_opcode    = ALU_OP_ADD;
                    end
                    OP_INC16: begin
                        alu_operand_B = 8'h01;
                        alu_opcode    = ALU_OP_ADD;
                    end
                    OP_DEC16: begin
                        alu_operand_B = 8'h01;
                        alu_opcode    = ALU_OP_SUB;
                    end
                    default: begin
                        alu_operand_B = b_q[7:0];
                        alu_opcode    = ALU_OP_ADD;
                    end
                endcase
            end
            S_HI: begin
                alu_operand_A = a_q[15:8];
                case (op_q)
                    OP_ADD16: begin
                        alu_operand_B = b_q[15:8];
                        alu_opcode    = ALU_OP_ADC;
                    end
                    OP_INC16: begin
                        alu_operand_B = 8'h00;
                        alu_opcode    = ALU_OP_ADC;
                    end
                    OP_DEC16: begin
                        alu_operand_B = 8'h00;
                        alu_opcode    = ALU_OP_SBC;
                    end
                    default: begin
                        alu_operand_B = {8{b_q[7]}};
                        alu_opcode    = ALU_OP_ADC;
                    end
                endcase
            end
            S_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Final flags: ADD16 uses the high-byte carries, ADD SP,e8 the low-byte ones.
    always_comb begin
        flags_next = flags_q;
        case (op_q)
            OP_ADD16:     flags_next = {flags_q[3], 1'b0, byte_h, byte_c_add};
            OP_ADD_SP_E8: flags_next = {2'b00, h_lo_q, c_lo_q};
            default:      flags_next = flags_q;
        endcase
    end

    // Datapath: capture the request, the low byte and its carries, then the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_ADD16;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            flags_q    <= 4'h0;
            res_lo_q   <= 8'h00;
            h_lo_q     <= 1'b0;
            c_lo_q     <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_flags  <= 4'h0;
        end else begin
            if (accept) begin
                op_q    <= op_t'(req_op);
                a_q     <= req_a;
                b_q     <= req_b;
                flags_q <= req_flags;
            end
            if (lo_step) begin
                res_lo_q <= alu_result;
                h_lo_q   <= byte_h;
                c_lo_q   <= (op_q == OP_DEC16) ? byte_b_sub : byte_c_add;
            end
            if (hi_step) begin
                rsp_result <= {alu_result, res_lo_q};
                rsp_flags  <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: randomized and directed bench for alu_seq16 with a behavioural
// 8-bit ALU stub and a 16-bit arithmetic reference model.

module tb_alu_seq16;
    import gate_boy_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    phi;
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic [15:0]             req_a;
    logic [15:0]             req_b;
    logic [3:0]              req_flags;
    logic [DATA_WIDTH-1:0]   alu_operand_A;
    logic [DATA_WIDTH-1:0]   alu_operand_B;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [15:0]             rsp_result;
    logic [3:0]              rsp_flags;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    alu_seq16 dut (
        .clk          (clk),
        .rst          (rst),
        .phi          (phi),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_flags    (req_flags),
        .alu_operand_A(alu_operand_A),
        .alu_operand_B(alu_operand_B),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // M-cycle strobe: one clk high, then 1..4 clks low.
    initial begin
        phi = 1'b0;
        forever begin
            @(negedge clk);
            phi = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                phi = 1'b0;
            end
        end
    end

    // ALU stub arithmetic: 9-bit sum or difference, bit 8 is carry/borrow.
    logic       alu_carry;
    logic [8:0] alu_tmp;
    always_comb begin
        case (alu_opcode)
            ALU_OP_ADC: alu_tmp = {1'b0, alu_operand_A} + {1'b0, alu_operand_B} + {8'h00, alu_carry};
            ALU_OP_SUB: alu_tmp = {1'b0, alu_operand_A} - {1'b0, alu_operand_B};
            ALU_OP_SBC: alu_tmp = {1'b0, alu_operand_A} - {1'b0, alu_operand_B} - {8'h00, alu_carry};
            default:    alu_tmp = {1'b0, alu_operand_A} + {1'b0, alu_operand_B};
        endcase
    end

    // ALU stub register: result every clk, carry held across ADC/SBC.
    always @(posedge clk) begin
        if (rst) begin
            alu_result <= 8'h00;
            alu_carry  <= 1'b0;
        end else begin
            alu_result <= alu_tmp[7:0];
            if (alu_opcode == ALU_OP_ADD || alu_opcode == ALU_OP_SUB) alu_carry <= alu_tmp[8];
        end
    end

    // Reference: {flags, result} straight from 16-bit arithmetic.
    function automatic logic [19:0] refModel(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [3:0] fl);
        int unsigned ua, ub, e, s;
        logic        h, c;
        logic [15:0] r;
        logic [3:0]  f;
        ua = a;
        ub = b;
        case (op)
            2'd0: begin
                s = ua + ub;
                r = 16'(s);
                h = ((ua & 32'hFFF) + (ub & 32'hFFF)) > 32'hFFF;
                c = s > 32'hFFFF;
                f = {fl[3], 1'b0, h, c};
            end
            2'd1: begin
                r = 16'(ua + 1);
                f = fl;
            end
            2'd2: begin
                r = 16'(ua - 1);
                f = fl;
            end
            default: begin
                e = ((ub & 32'h80) != 0) ? ((ub & 32'hFF) | 32'hFF00) : (ub & 32'hFF);
                r = 16'(ua + e);
                h = ((ua & 32'hF) + (ub & 32'hF)) > 32'hF;
                c = ((ua & 32'hFF) + (ub & 32'hFF)) > 32'hFF;
                f = {2'b00, h, c};
            end
        endcase
        return {f, r};
    endfunction

    logic [19:0] ref_out;
    always_comb ref_out = refModel(req_op, req_a, req_b, req_flags);

    // Transaction-level model: counts phi edges since acceptance.
    logic        m_pending = 1'b0;
    logic        m_valid   = 1'b0;
    int          m_phis    = 0;
    logic [1:0]  m_op      = 2'd0;
    logic [15:0] m_a       = 16'h0;
    logic [15:0] m_b       = 16'h0;
    logic [19:0] m_exp     = 20'h0;
    logic [15:0] m_result  = 16'h0;
    logic [3:0]  m_flags   = 4'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_pending <= 1'b0;
            m_valid   <= 1'b0;
            m_phis    <= 0;
            m_result  <= 16'h0;
            m_flags   <= 4'h0;
        end else if (m_valid) begin
            if (rsp_ready) m_valid <= 1'b0;
        end else if (m_pending) begin
            if (phi) begin
                if (m_phis == 1) begin
                    m_pending <= 1'b0;
                    m_valid   <= 1'b1;
                    m_result  <= m_exp[15:0];
                    m_flags   <= m_exp[19:16];
                end else begin
                    m_phis <= m_phis + 1;
                end
            end
        end else if (phi && req_valid) begin
            m_pending <= 1'b1;
            m_phis    <= 0;
            m_op      <= req_op;
            m_a       <= req_a;
            m_b       <= req_b;
            m_exp     <= ref_out;
        end
    end

    // Expected ALU bus: low byte step, high byte step, or idle ADD 0+0.
    logic [7:0]              exp_a;
    logic [7:0]              exp_b;
    logic [OPCODE_WIDTH-1:0] exp_op;
    always_comb begin
        exp_a  = 8'h00;
        exp_b  = 8'h00;
        exp_op = ALU_OP_ADD;
        if (m_pending && m_phis == 0) begin
            exp_a  = m_a[7:0];
            exp_b  = (m_op == 2'd0 || m_op == 2'd3) ? m_b[7:0] : 8'h01;
            exp_op = (m_op == 2'd2) ? ALU_OP_SUB : ALU_OP_ADD;
        end else if (m_pending) begin
            exp_a  = m_a[15:8];
            exp_b  = (m_op == 2'd0) ? m_b[15:8] : (m_op == 2'd3) ? {8{m_b[7]}} : 8'h00;
            exp_op = (m_op == 2'd2) ? ALU_OP_SBC : ALU_OP_ADC;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("req_ready", 16'(req_ready), 16'(!(m_pending || m_valid)));
            checkOutput("rsp_valid", 16'(rsp_valid), 16'(m_valid));
            checkOutput("alu_operand_A", 16'(alu_operand_A), 16'(exp_a));
            checkOutput("alu_operand_B", 16'(alu_operand_B), 16'(exp_b));
            checkOutput("alu_opcode", 16'(alu_opcode), 16'(exp_op));
            if (m_valid) begin
                checkOutput("rsp_result", rsp_result, m_result);
                checkOutput("rsp_flags", 16'(rsp_flags), 16'(m_flags));
            end
        end
    end

    // Present a request (called just after a negedge) and wait for its acceptance edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] fl);
        bit done;
        int n;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_flags = fl;
        req_valid = 1'b1;
        done      = 1'b0;
        n         = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            if (phi && req_ready) done = 1'b1;
            n++;
        end
        if (!done) checkOutput("accept_timeout", 16'(done), 16'h1);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_flags = 4'($urandom);
    endtask

    task automatic waitResponse(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 60) begin
            if (rsp_valid) ok = 1'b1;
            else @(negedge clk);
            n++;
        end
        if (!ok) checkOutput("rsp_timeout", 16'(ok), 16'h1);
    endtask

    task automatic finishResponse(input int delay);
        repeat (delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic runDirected(input string name, input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [3:0] fl,
                               input logic [15:0] exp_r, input logic [3:0] exp_f);
        bit ok;
        applyStimulus(op, a, b, fl);
        waitResponse(ok);
        if (ok) begin
            checkOutput({name, "_result"}, rsp_result, exp_r);
            checkOutput({name, "_flags"}, 16'(rsp_flags), 16'(exp_f));
        end
        finishResponse($urandom_range(0, 2));
    endtask

    initial begin
        bit         ok;
        bit         seen;
        int         n;
        logic [1:0] op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fl;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        req_flags = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_rsp_valid", 16'(rsp_valid), 16'h0);
        checkOutput("reset_req_ready", 16'(req_ready), 16'h1);
        checkOutput("reset_rsp_result", rsp_result, 16'h0000);
        checkOutput("reset_rsp_flags", 16'(rsp_flags), 16'h0);
        checkOutput("reset_alu_a", 16'(alu_operand_A), 16'h0);
        checkOutput("reset_alu_opcode", 16'(alu_opcode), 16'(ALU_OP_ADD));
        check_en = 1'b1;

        $display("[TB] directed vectors");
        runDirected("add16_0fff", 2'd0, 16'h0FFF, 16'h0001, 4'h8, 16'h1000, 4'hA);
        runDirected("add16_ffff", 2'd0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'h3);
        runDirected("dec16_0000", 2'd2, 16'h0000, 16'h1234, 4'hA, 16'hFFFF, 4'hA);
        runDirected("inc16_00ff", 2'd1, 16'h00FF, 16'h5678, 4'h5, 16'h0100, 4'h5);
        runDirected("inc16_ffff", 2'd1, 16'hFFFF, 16'h0000, 4'h3, 16'h0000, 4'h3);
        runDirected("sp_fff8_08", 2'd3, 16'hFFF8, 16'h0008, 4'hF, 16'h0000, 4'h3);
        runDirected("sp_0000_ff", 2'd3, 16'h0000, 16'h00FF, 4'hF, 16'hFFFF, 4'h0);

        $display("[TB] response back-pressure");
        applyStimulus(2'd0, 16'h1234, 16'h1111, 4'hF);
        waitResponse(ok);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", 16'(rsp_valid), 16'h1);
            checkOutput("hold_result", rsp_result, 16'h2345);
            checkOutput("hold_flags", 16'(rsp_flags), 16'h8);
            if (i == 3) begin
                req_op    = 2'd1;
                req_a     = 16'h00FF;
                req_b     = 16'h0000;
                req_flags = 4'h5;
                req_valid = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("handshake_req_ready", 16'(req_ready), 16'h1);
        checkOutput("handshake_rsp_valid", 16'(rsp_valid), 16'h0);
        applyStimulus(2'd1, 16'h00FF, 16'h0000, 4'h5);
        waitResponse(ok);
        if (ok) checkOutput("held_req_result", rsp_result, 16'h0100);
        finishResponse(1);

        $display("[TB] reset during high byte");
        applyStimulus(2'd0, 16'hABCD, 16'h1111, 4'h0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            if (phi) seen = 1'b1;
            n++;
        end
        if (!seen) checkOutput("hi_timeout", 16'(seen), 16'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_rsp_valid", 16'(rsp_valid), 16'h0);
        checkOutput("midreset_req_ready", 16'(req_ready), 16'h1);
        runDirected("post_reset_add", 2'd0, 16'h0FFF, 16'h0001, 4'h0, 16'h1000, 4'h2);

        $display("[TB] random transactions");
        for (int t = 0; t < 150; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            fl = 4'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 16'hFFFF;
                1:       a = 16'h0000;
                2:       b = 16'hFFFF;
                3:       b = 16'h0080;
                default: a = a;
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(op, a, b, fl);
            waitResponse(ok);
            finishResponse($urandom_range(0, 4));
        end

        repeat (5) @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 Ports: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  4 MHz system clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 phi  in  1  M-cycle strobe, one clk wide, pulses separated by >=1 low clk; FSM advances only on edges with phi=1.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  high iff FSM in IDLE.
REQ-007 req_op  in  2  0=ADD16 (ADD HL,rr), 1=INC16, 2=DEC16, 3=ADD_SP_E8.
REQ-008 req_a  in  16  first operand (HL, rr or SP).
REQ-009 req_b  in  16  second operand; ADD_SP_E8 uses req_b[7:0] as signed e8; ignored by INC16/DEC16.
REQ-010 req_flags  in  4  current {Z,N,H,C}, passed through where unchanged.
REQ-011 alu_operand_A, alu_operand_B  out  DATA_WIDTH(8) each  operands to shared 8-bit ALU.
REQ-012 alu_opcode  out  OPCODE_WIDTH  ALU_OP_ADD/ADC/SUB/SBC constants from gate_boy_pkg.
REQ-013 alu_result  in  8  ALU output, registered by ALU, valid 1 clk after operands/opcode stable.
REQ-014 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  16; rsp_flags  out  4 {Z,N,H,C}.

Function
REQ-015 States: IDLE, LO, HI, DONE.
REQ-016 IDLE->LO on clk edge with phi & req_valid; req_op/req_a/req_b/req_flags captured internally that edge.
REQ-017 LO: drive low bytes: ADD16 ADD(a_lo,b_lo); INC16 ADD(a_lo,0x01); DEC16 SUB(a_lo,0x01); ADD_SP_E8 ADD(a_lo,e8).
REQ-018 LO->HI on next phi edge: capture alu_result as res_lo; latch carry c8 and half-carry c4 derived from a,b,r bytes.
REQ-019 Add carry: c4=a4^b4^r4; c8=(a7&b7)|((a7|b7)&~r7) plus c7 term per full-adder majority(a7,b7,a7^b7^r7).
REQ-020 Sub borrow (DEC16): borrow8=(~a7&b7)|(~(a7^b7)&r7).
REQ-021 HI: drive high bytes with carry-in opcode: ADD16 ADC(a_hi,b_hi); INC16 ADC(a_hi,0x00); DEC16 SBC(a_hi,0x00); ADD_SP_E8 ADC(a_hi, e8[7]?0xFF:0x00).
REQ-022 ALU carry-in for HI equals latched c8/borrow8 (ALU holds it from its own LO result; block does not re-drive a carry).
REQ-023 HI->DONE on next phi edge: rsp_result={alu_result,res_lo}; rsp_valid=1.
REQ-024 Flags: ADD16 Z=req_flags.Z, N=0, H=c12 (from high byte), C=c16; INC16/DEC16 all = req_flags; ADD_SP_E8 Z=0,N=0,H=c4,C=c8 of low byte.
REQ-025 DONE: rsp_* held stable until rsp_valid&rsp_ready on any clk edge (phi not required); then IDLE next clk.
REQ-026 No request accepted in the same clk as rsp handshake; earliest acceptance next phi edge in IDLE.
REQ-027 Latency: rsp_valid rises exactly 2 phi edges after acceptance edge (8 clk at nominal phi).
REQ-028 alu_* outputs in IDLE and DONE: operands 0x00, opcode ALU_OP_ADD.
REQ-029 All arithmetic modulo 2^16; wrap 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
REQ-030 phi pulses on consecutive clks: behaviour undefined; bench shall not generate.

Reset
REQ-031 rst=1 at clk edge: state IDLE, rsp_valid=0, rsp_result=0x0000, rsp_flags=0x0, alu operands 0x00, opcode ALU_OP_ADD, req_ready=1 next clk.
REQ-032 rst in LO/HI/DONE abandons operation; no response produced; rst overrides phi and handshakes.

Verification
REQ-033 ADD16 a=0x0FFF b=0x0001 flags=0x8 -> after 2 phi: result 0x1000, flags Z1 N0 H1 C0.
REQ-034 ADD16 a=0xFFFF b=0x0001 flags=0x0 -> result 0x0000, flags Z0 N0 H1 C1.
REQ-035 DEC16 a=0x0000 flags=0xA -> result 0xFFFF, flags 0xA; INC16 a=0x00FF -> 0x0100.
REQ-036 ADD_SP_E8 a=0xFFF8 e8=0x08 -> result 0x0000, Z0 N0 H1 C1; e8=0xFF a=0x0000 -> 0xFFFF, H0 C0.
REQ-037 rsp_ready low 5 clks in DONE -> rsp_valid/result/flags stable; handshake -> req_ready=1 next clk; req_valid held throughout not accepted until next phi.
REQ-038 rst pulsed while in HI -> next clk IDLE, rsp_valid=0; following ADD16 completes correctly.
